// File: rtl/sha2_apb_if.sv
// APB slave-side bus bundle for the SHA-256 accelerator.
// Signal names follow the system APB wiring.
interface sha2_apb_if;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/sha2_apb.sv
// APB-mapped SHA-256 compression engine (one round per clock) with an 8-bit GPIO port
// and a level interrupt on completion.
module sha2_apb (
    input  logic       HCLK,
    input  logic       HRESETn,
    sha2_apb_if.slave  apb,
    input  logic [7:0] upio_in_i,
    output logic [7:0] upio_out_o,
    output logic [7:0] upio_dir_o,
    output logic       int_o
);
    localparam int unsigned WA_W  = 10;
    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0] FINAL_STEP = CNT_W'(64);

    localparam logic [WA_W-1:0] A_CTRL   = WA_W'(0);
    localparam logic [WA_W-1:0] A_STATUS = WA_W'(1);
    localparam logic [WA_W-1:0] A_GOUT   = WA_W'(2);
    localparam logic [WA_W-1:0] A_GDIR   = WA_W'(3);
    localparam logic [WA_W-1:0] A_GIN    = WA_W'(4);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ie, done;
    logic [31:0]      blk [16];
    logic [31:0]      dig [8];
    logic [31:0]      wk  [8];
    logic [31:0]      w   [16];

    logic [WA_W-1:0]  wa;
    logic             access, wr, is_blk, is_dig, mapped, err;
    logic             busy, finishing, init, start_ok;
    logic [31:0]      t1, t2, w_new, rdata;
    logic [31:0]      h_fin   [8];
    logic [31:0]      dig_nxt [8];
    logic             unused_addr_lsb;

    assign wa        = apb.PADDR[11:2];
    assign access    = apb.PSEL & apb.PENABLE;
    assign wr        = access & apb.PWRITE;
    assign is_blk    = (wa[9:4] == 6'd1);
    assign is_dig    = (wa[9:3] == 7'd4);
    assign mapped    = (wa <= A_GIN) | is_blk | is_dig;
    assign busy      = (state == S_RUN);
    assign finishing = busy & (cnt == FINAL_STEP);
    assign init      = wr & (wa == A_CTRL) & apb.PWDATA[1];
    // A start on the finishing edge is legal and chains from the fresh digest.
    assign start_ok  = wr & (wa == A_CTRL) & apb.PWDATA[0] & (~busy | finishing);
    assign err       = access & (~mapped | (apb.PWRITE & ((wa == A_GIN) | is_dig | (is_blk & busy))));
    assign unused_addr_lsb = ^apb.PADDR[1:0];

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = err;
    assign apb.PRDATA  = rdata;
    assign int_o       = done & ie;

    // Round datapath, message-schedule extension and final digest accumulation.
    always_comb begin
        t1 = wk[7] + (ror(wk[4], 6) ^ ror(wk[4], 11) ^ ror(wk[4], 25))
           + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[cnt[5:0]] + w[0];
        t2 = (ror(wk[0], 2) ^ ror(wk[0], 13) ^ ror(wk[0], 22))
           + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
        w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
        for (int i = 0; i < 8; i++) begin
            h_fin[i]   = dig[i] + wk[i];
            dig_nxt[i] = init ? IV[i] : (finishing ? h_fin[i] : dig[i]);
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            if (is_blk)      rdata = blk[wa[3:0]];
            else if (is_dig) rdata = dig[wa[2:0]];
            else begin
                case (wa)
                    A_CTRL:   rdata = {29'd0, ie, 2'b00};
                    A_STATUS: rdata = {30'd0, done, busy};
                    A_GOUT:   rdata = {24'd0, upio_out_o};
                    A_GDIR:   rdata = {24'd0, upio_dir_o};
                    A_GIN:    rdata = {24'd0, upio_in_i};
                    default:  rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ie         <= 1'b0;
            done       <= 1'b0;
            upio_out_o <= '0;
            upio_dir_o <= '0;
            for (int i = 0; i < 16; i++) begin
                blk[i] <= '0;
                w[i]   <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                dig[i] <= IV[i];
                wk[i]  <= '0;
            end
        end else begin
            if (wr && wa == A_CTRL) ie         <= apb.PWDATA[2];
            if (wr && wa == A_GOUT) upio_out_o <= apb.PWDATA[7:0];
            if (wr && wa == A_GDIR) upio_dir_o <= apb.PWDATA[7:0];
            if (wr && is_blk && !busy) blk[wa[3:0]] <= apb.PWDATA;

            for (int i = 0; i < 8; i++) dig[i] <= dig_nxt[i];

            // Completion set has priority over any clear on the same edge.
            if (finishing)
                done <= 1'b1;
            else if (start_ok || (wr && wa == A_STATUS && apb.PWDATA[1]))
                done <= 1'b0;

            if (start_ok) begin
                state <= S_RUN;
                cnt   <= '0;
                for (int i = 0; i < 8; i++)  wk[i] <= dig_nxt[i];
                for (int i = 0; i < 16; i++) w[i]  <= blk[i];
            end else if (finishing) begin
                state <= S_IDLE;
            end else if (busy) begin
                cnt   <= cnt + CNT_W'(1);
                wk[7] <= wk[6];
                wk[6] <= wk[5];
                wk[5] <= wk[4];
                wk[4] <= wk[3] + t1;
                wk[3] <= wk[2];
                wk[2] <= wk[1];
                wk[1] <= wk[0];
                wk[0] <= t1 + t2;
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
            end
        end
    end
endmodule

// File: tb/tb_sha2_apb.sv
// Scoreboard bench for sha2_apb: bus transactions queue expected responses, a monitor
// checks them in the access phase; pin-level results are checked directly.
module tb_sha2_apb;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic [7:0] upio_in_i = 8'h00;
    logic [7:0] upio_out_o, upio_dir_o;
    logic       int_o;

    sha2_apb_if apb ();

    sha2_apb dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .apb        (apb),
        .upio_in_i  (upio_in_i),
        .upio_out_o (upio_out_o),
        .upio_dir_o (upio_dir_o),
        .int_o      (int_o)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    string       q_name [$];
    logic [31:0] q_data [$];
    logic        q_chk  [$];
    logic        q_err  [$];

    // Monitor: every access phase pops one expected response.
    always @(negedge HCLK) begin
        if (!HRESETn && apb.PSEL && apb.PENABLE) begin
            if (q_name.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_access: addr=%h with empty scoreboard", apb.PADDR);
            end else begin
                string       nm;
                logic [31:0] ed;
                logic        ec, ee;
                nm = q_name.pop_front(); ed = q_data.pop_front();
                ec = q_chk.pop_front();  ee = q_err.pop_front();
                checks++;
                if (apb.PSLVERR !== ee || apb.PREADY !== 1'b1) begin
                    errors++;
                    $display("FAIL %s: pslverr=%b pready=%b, required pslverr=%b pready=1",
                             nm, apb.PSLVERR, apb.PREADY, ee);
                end
                if (ec) begin
                    checks++;
                    if (apb.PRDATA !== ed) begin
                        errors++;
                        $display("FAIL %s: prdata=%h required %h", nm, apb.PRDATA, ed);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input logic chk, input logic exp_err, input string name);
        q_name.push_back(name); q_data.push_back(exp);
        q_chk.push_back(chk);   q_err.push_back(exp_err);
        @(posedge HCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata;
        @(posedge HCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge HCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] d, input logic e, input string name);
        xfer(1'b1, addr, d, 32'h0, 1'b0, e, name);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input logic e, input string name);
        xfer(1'b0, addr, 32'h0, exp, 1'b1, e, name);
    endtask

    task automatic load_block(input logic [31:0] blk [16]);
        for (int i = 0; i < 16; i++) wr(12'h040 + 12'(4 * i), blk[i], 1'b0, "blk_wr");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    logic [31:0] abc_blk [16];
    logic [31:0] abc_dig [8];
    logic [31:0] empty_blk [16];
    logic [31:0] two_b1 [16];
    logic [31:0] two_b2 [16];
    int unsigned t0;

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0;  apb.PWDATA = '0;

        abc_blk = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        abc_dig = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        empty_blk = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        two_b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b2 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_int", 32'(int_o), 32'h0);
        check("rst_pready", 32'(apb.PREADY), 32'h1);
        check("rst_gpio_out", 32'(upio_out_o), 32'h0);
        check("rst_gpio_dir", 32'(upio_dir_o), 32'h0);
        @(negedge HCLK) HRESETn = 1'b0;
        rd(12'h080, 32'h6a09e667, 1'b0, "rst_h0");
        rd(12'h09c, 32'h5be0cd19, 1'b0, "rst_h7");
        rd(12'h004, 32'h0, 1'b0, "rst_status");
        rd(12'h000, 32'h0, 1'b0, "rst_ctrl");
        rd(12'h008, 32'h0, 1'b0, "rst_gout");
        rd(12'h00c, 32'h0, 1'b0, "rst_gdir");

        // "abc" with INIT+START+IE
        load_block(abc_blk);
        wr(12'h000, 32'h7, 1'b0, "abc_start");
        t0 = cyc;
        rd(12'h004, 32'h1, 1'b0, "abc_busy");
        rd(12'h080, 32'h6a09e667, 1'b0, "abc_h0_prehash");
        wr(12'h044, 32'hdeadbeef, 1'b1, "blk_wr_busy");
        wr(12'h000, 32'h5, 1'b0, "start_while_busy");
        while (!int_o && (cyc - t0) < 200) begin
            @(posedge HCLK); #1;
        end
        check("abc_latency", cyc - t0, 32'd65);
        check("abc_int", 32'(int_o), 32'h1);
        rd(12'h004, 32'h2, 1'b0, "abc_done");
        for (int i = 0; i < 8; i++) rd(12'h080 + 12'(4 * i), abc_dig[i], 1'b0, "abc_digest");
        rd(12'h044, 32'h0, 1'b0, "blk_w1_unchanged");
        rd(12'h040, 32'h61626380, 1'b0, "blk_w0_kept");

        // DONE write-1-clear drops the interrupt
        wr(12'h004, 32'h2, 1'b0, "done_w1c");
        rd(12'h004, 32'h0, 1'b0, "status_cleared");
        check("int_after_w1c", 32'(int_o), 32'h0);
        rd(12'h000, 32'h4, 1'b0, "ie_readback");
        wr(12'h000, 32'h0, 1'b0, "ie_clear");

        // Protection and unmapped
        wr(12'h084, 32'h0, 1'b1, "digest_wr_err");
        rd(12'h084, 32'h8f01cfea, 1'b0, "digest_unchanged");
        rd(12'h200, 32'h0, 1'b1, "unmapped_rd");
        rd(12'h014, 32'h0, 1'b1, "gap_rd");
        wr(12'h010, 32'hff, 1'b1, "gpio_in_wr_err");

        // Empty message, IE=0
        load_block(empty_blk);
        wr(12'h000, 32'h3, 1'b0, "empty_start");
        idle(70);
        rd(12'h004, 32'h2, 1'b0, "empty_done");
        check("empty_int", 32'(int_o), 32'h0);
        rd(12'h080, 32'he3b0c442, 1'b0, "empty_h0");
        rd(12'h09c, 32'h7852b855, 1'b0, "empty_h7");

        // Two-block chaining
        load_block(two_b1);
        wr(12'h000, 32'h3, 1'b0, "two_b1_start");
        idle(70);
        load_block(two_b2);
        wr(12'h000, 32'h1, 1'b0, "two_b2_start");
        idle(70);
        rd(12'h080, 32'h248d6a61, 1'b0, "two_h0");
        rd(12'h09c, 32'h19db06c1, 1'b0, "two_h7");

        // GPIO
        wr(12'h00c, 32'hf0, 1'b0, "gdir_wr");
        wr(12'h008, 32'ha5, 1'b0, "gout_wr");
        check("pin_dir", 32'(upio_dir_o), 32'hf0);
        check("pin_out", 32'(upio_out_o), 32'ha5);
        upio_in_i = 8'h3c;
        rd(12'h010, 32'h3c, 1'b0, "gpio_in_rd");
        rd(12'h008, 32'ha5, 1'b0, "gout_rd");

        // Reset in the middle of a hash
        wr(12'h000, 32'h5, 1'b0, "mid_start");
        idle(10);
        @(negedge HCLK) HRESETn = 1'b1;
        @(negedge HCLK);
        check("mid_rst_int", 32'(int_o), 32'h0);
        check("mid_rst_out", 32'(upio_out_o), 32'h0);
        check("mid_rst_dir", 32'(upio_dir_o), 32'h0);
        HRESETn = 1'b0;
        rd(12'h004, 32'h0, 1'b0, "mid_rst_status");
        rd(12'h080, 32'h6a09e667, 1'b0, "mid_rst_h0");
        rd(12'h040, 32'h0, 1'b0, "mid_rst_blk");

        idle(4);
        checks++;
        if (q_name.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", q_name.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sha2_apb.md
# sha2_apb

APB-mapped SHA-256 accelerator with an 8-bit general-purpose I/O port and a level interrupt. Software loads one 512-bit pre-padded message block and starts a compression. The engine runs one round per clock and accumulates the result into an 8-word digest. Sits as a peripheral slave on the system APB bus behind the top-level wrapper.

## Interface
- No parameters.
- HCLK  in  1  single clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-high reset. The name is kept for bus compatibility, but the polarity is high.
- PADDR  in  12  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PRDATA  out  32  read data. Valid when PSEL & ~PWRITE; 0 otherwise.
- PREADY  out  1  tied to 1 (zero wait states).
- PSLVERR  out  1  error for the current access phase.
- upio_in_i  in  8  GPIO input pins.
- upio_out_o  out  8  GPIO output register.
- upio_dir_o  out  8  GPIO direction register (1 = output).
- int_o  out  1  interrupt = STATUS.DONE & CTRL.IE.

## Operation
- A write takes effect at the clock edge where PSEL & PENABLE & PWRITE. Reads are combinational from PADDR.
- Register map:
  - 0x000 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 INIT: write-1 pulse, reads 0.
    - bit2 IE: read/write.
  - 0x004 STATUS:
    - bit0 BUSY: read-only.
    - bit1 DONE: sticky; write 1 to clear.
  - 0x008 GPIO_OUT[7:0] (RW).
  - 0x00C GPIO_DIR[7:0] (RW).
  - 0x010 GPIO_IN: returns upio_in_i, read-only.
  - 0x040–0x07C BLOCK W0..W15: RW, W0 at 0x040, big-endian message words.
  - 0x080–0x09C DIGEST H0..H7: read-only.
- Unmapped addresses read 0. PSLVERR=1 during the access phase for:
  - any unmapped address;
  - a write to GPIO_IN or DIGEST;
  - a write to BLOCK while BUSY. The write is discarded.
- INIT loads the standard IV into H0..H7:
  - 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- START when idle:
  - copies BLOCK into an internal 16-word schedule window;
  - loads working registers a..h from H;
  - clears DONE;
  - sets BUSY.
- START while BUSY is ignored; no error is raised.
- INIT and START in the same write: IV is loaded first, and the compression uses the IV.
- Without INIT, a compression chains from the current digest (multi-block messages).
- Rounds t=0..63 use the FIPS 180-4 SHA-256 functions and K constants:
  - W[t] for t≥16 comes from the sliding window: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16];
  - all additions are mod 2^32.
- After round 63: Hi ← Hi + working register (mod 2^32), BUSY→0, DONE→1.
- The BLOCK registers are not modified by hashing.
- Padding is software's responsibility.

## Timing
- Reset values:
  - CTRL.IE=0, BUSY=0, DONE=0;
  - GPIO_OUT=0, GPIO_DIR=0, BLOCK=0, DIGEST=IV;
  - upio_out_o=0, upio_dir_o=0, int_o=0, PSLVERR=0, PREADY=1.
- Reset mid-hash aborts immediately and restores all reset values.
- Let E0 be the edge that accepts START:
  - BUSY=1 after E0;
  - rounds 0..63 execute on edges E1..E64;
  - the digest update, BUSY=0 and DONE=1 occur on E65.
- Total latency: 65 clocks from the START write edge to DONE.
- int_o is registered-equivalent: it rises the cycle DONE rises if IE=1, and follows IE/DONE changes the next cycle.
- A DONE write-1-clear on the same edge DONE sets: the set wins.
- A START on that same edge (E65) is accepted; the new hash then starts from the updated digest.
- DIGEST reads during BUSY return the pre-hash values.
- GPIO writes take effect the edge of the access phase. upio_in_i is read combinationally, with no synchronizer in this block.

## Test plan
- Reset state: assert HRESETn=1, then release.
  - Reads: DIGEST H0=6a09e667, H7=5be0cd19; STATUS=0; GPIO=0.
  - Outputs: int_o=0, PREADY=1.
- "abc" vector: W0=61626380, W1..W14=0, W15=00000018; write CTRL=0x7.
  - BUSY is observed 1, then DONE after 65 clocks; int_o=1.
  - Digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message vector: W0=80000000, rest 0; write CTRL=0x3.
  - H0=e3b0c442, H7=7852b855; int_o stays 0 (IE=0).
- Two-block chaining, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 with INIT, block 2 with START only;
  - H0=248d6a61, H7=19db06c1.
- Errors and protection:
  - write to 0x084 → PSLVERR=1, digest unchanged;
  - read 0x200 → PRDATA=0, PSLVERR=1;
  - BLOCK write while BUSY → PSLVERR=1, data ignored;
  - START while BUSY → ignored;
  - DONE W1C → DONE=0 and int_o=0.
- GPIO: write DIR=0xF0, OUT=0xA5 → upio_dir_o=F0, upio_out_o=A5; drive upio_in_i=3C → GPIO_IN reads 0x3C.
